keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scan controller for the 4x4 matrix keypad. It drives one keypad column low at a time and samples the synchronized, active-low row inputs. It debounces press and release, then reports each accepted key as a 4-bit hex code with a single-cycle strobe. It sits between the two-flop row/column synchronizer and the display/digit-history logic that consumes key events.

## Interface
- SETTLE_CYCLES, default 4: cycles a column is driven before rows are sampled. Must be ≥ 3 (covers the 2-cycle synchronizer latency plus 1).
- DEBOUNCE_CYCLES, default 50000: number of consecutive stable cycles required to accept a press or a release.
- clk input 1: system clock.
- reset input 1: asynchronous, active-low; clock clk.
- row_sync input [3:0]: synchronized keypad rows, active-low (1 = no key).
- col output [3:0]: column drive, active-low, one-hot-zero (exactly one bit is 0 at all times).
- key_code output [3:0]: hex value of the last accepted key. Held until the next accepted key.
- key_valid output 1: one-cycle pulse when a press is accepted.
- key_held output 1: high while the accepted key is considered pressed, including the release debounce.

## Operation
- Key map, row r / column c: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = E 0 F D. key_code = the listed hex digit.
- State SCAN
  - Drive col[idx] = 0 and count SETTLE_CYCLES.
  - At the end of the count, sample row_sync.
  - If any bit is low: latch the lowest-index low row as r_cap, keep idx, clear the counter, and go to PRESS_DB.
  - Otherwise idx = idx+1 mod 4 (wraps 3→0), clear the counter, and stay in SCAN.
- State PRESS_DB
  - Column frozen. Count while row_sync[r_cap] == 0.
  - If row_sync[r_cap] == 1 on any cycle: abandon, advance idx, go to SCAN. No event is emitted.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low: register key_code, pulse key_valid, go to HELD.
- State HELD
  - Column frozen, key_held = 1.
  - Other rows are ignored, so a second simultaneous key is never reported.
  - When row_sync[r_cap] == 1: clear the counter and go to RELEASE_DB.
- State RELEASE_DB
  - key_held stays 1. Count while row_sync[r_cap] == 1.
  - If the row returns low: go back to HELD. No new key_valid.
  - When the counter reaches DEBOUNCE_CYCLES-1: key_held = 0, advance idx, go to SCAN.
- Counter width is $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)+1). Counters saturate; they never wrap.

## Timing
- Reset values: col = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, state SCAN, idx 0, counters 0.
- Reset asserted mid-operation returns all of the above immediately (asynchronous). No key_valid is emitted on reset or on release from reset.
- All outputs are registered.
- key_valid is high for exactly 1 cycle per accepted press. key_code changes on the same edge that key_valid rises.
- Minimum press-to-key_valid latency, measured from the sample cycle in SCAN: DEBOUNCE_CYCLES cycles. Add up to 4×SETTLE_CYCLES of scan delay before that.
- key_held rises together with key_valid. It falls DEBOUNCE_CYCLES cycles after row_sync[r_cap] first reads 1 with no bounce.
- col changes only on SCAN counter expiry. It never changes in PRESS_DB, HELD or RELEASE_DB.
- Key on a column already passed: detected on the next scan lap.

## Structure
- Shared package keypad_pkg holds:
  - the state enum `scan_state_t` (SCAN, PRESS_DB, HELD, RELEASE_DB);
  - the constant 4-entry × 4 key-map array, indexed [row][col];
  - localparam NO_KEY = 4'b1111.
- Sub-module keypad_decoder: combinational (r_cap, idx) → hex lookup against the package map. It is reused by the test bench scoreboard.
- The synchronizer stays outside this block. The top level wires row_sync from the synchronizer and col to the pins.

## Test plan
Simulation parameters: SETTLE_CYCLES = 4, DEBOUNCE_CYCLES = 8.
- Reset then idle rows = 4'hF: col cycles 1110→1101→1011→0111→1110, each held 4 cycles. key_valid never asserts.
- Clean press of r1/c2 held for 40 cycles: exactly one key_valid pulse, key_code = 4'h6, key_held high. col frozen at 4'b1011 until release debounce completes.
- Bounce: row low 3 cycles, high 1, then low steadily: the first attempt is abandoned with no pulse. A later scan lap yields one pulse, key_code = 4'h6.
- Release bounce: high 3 cycles, low 2, then high steadily: no second key_valid. key_held falls 8 cycles after the final rising edge. Scanning resumes at col 4'b0111.
- Two keys, r3/c1 (0) and r0/c3 (A), pressed together: only the first scanned key (0, on col1) is reported. A is reported only after 0 is released.
- Reset asserted during HELD: col = 4'b1110, key_code = 0, key_held = 0 immediately. No pulse follows deassertion while the rows are idle.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   scan_state_t - scanner FSM states
//   KEY_MAP      - hex code of each key, indexed [row][col]
//   NO_KEY       - row_sync pattern when no row is pulled low
//   col_drive()  - active-low one-hot column drive for a column index
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_t;

  // Rows are active-low, so all-ones means nothing is pressed on the
  // currently driven column.
  localparam logic [3:0] NO_KEY = 4'b1111;

  // Physical legend of the keypad, row-major.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Exactly one column is pulled low at any time.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_if
// Bundles the keypad-side and event-side signals of the scanner.
//   row_sync  - synchronized keypad rows, active-low
//   col       - column drive, active-low one-hot-zero
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle strobe per accepted press
//   key_held  - accepted key still considered pressed
// Modports:
//   slave  - the scanner itself
//   master - the surrounding logic (synchronizer/pins/consumer)
// -----------------------------------------------------------------------------
interface keypad_if;

  logic [3:0] row_sync;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport slave (
    input  row_sync,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport master (
    output row_sync,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/keypad_decoder.sv
// -----------------------------------------------------------------------------
// keypad_decoder
// Combinational lookup of the hex code for a (row, column) key position.
//   row_i  [1:0] - row index of the pressed key
//   col_i  [1:0] - column index of the pressed key
//   code_o [3:0] - hex code from KEY_MAP
// -----------------------------------------------------------------------------
module keypad_decoder
  import keypad_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [3:0] code_o
);

  assign code_o = KEY_MAP[row_i][col_i];

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces press
// and release of a single key and reports accepted presses as a hex code with
// a one-cycle strobe.
// Parameters:
//   SETTLE_CYCLES   - cycles each column is driven before rows are sampled
//                     (at least 3, to cover the external 2-flop synchronizer)
//   DEBOUNCE_CYCLES - consecutive stable cycles to accept a press or release
//                     (at least 2)
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low reset
//   kp    - keypad_if.slave: row_sync in; col, key_code, key_valid,
//           key_held out (all outputs registered)
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.slave  kp
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                             : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  // The counter steps to DEBOUNCE_CYCLES-1 on the accepting edge. Together
  // with the cycle that triggered entry (the SCAN sample, or the first high
  // read in HELD) this makes exactly DEBOUNCE_CYCLES stable cycles.
  localparam logic [CW-1:0] DB_ACCEPT   = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);

  scan_state_t state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    r_cap_q, r_cap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    col_q, col_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic [1:0]    first_low_row;
  logic          cap_row_low;
  logic [3:0]    dec_code;

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    first_low_row = 2'd3;
    casez (kp.row_sync)
      4'b???0: first_low_row = 2'd0;
      4'b??01: first_low_row = 2'd1;
      4'b?011: first_low_row = 2'd2;
      default: first_low_row = 2'd3;
    endcase
  end

  // Only the captured row is watched once a key is latched; other rows are
  // deliberately ignored so a second key cannot sneak in.
  assign cap_row_low = ~kp.row_sync[r_cap_q];

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

  keypad_decoder u_decoder (
    .row_i  (r_cap_q),
    .col_i  (idx_q),
    .code_o (dec_code)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    r_cap_d     = r_cap_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      SCAN: begin
        if (cnt_q >= SETTLE_LAST) begin
          cnt_d = '0;
          if (kp.row_sync != NO_KEY) begin
            r_cap_d = first_low_row;
            state_d = PRESS_DB;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      PRESS_DB: begin
        if (!cap_row_low) begin
          // Bounce or glitch: drop the attempt silently and move on.
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = SCAN;
        end else if (cnt_q >= DB_ACCEPT) begin
          cnt_d       = '0;
          key_code_d  = dec_code;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      HELD: begin
        if (!cap_row_low) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end
      end

      RELEASE_DB: begin
        if (cap_row_low) begin
          // Release bounce: the key is still down, no new event.
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q >= DB_ACCEPT) begin
          cnt_d      = '0;
          key_held_d = 1'b0;
          idx_d      = idx_q + 2'd1;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase

    // Column only moves when idx moves, i.e. on SCAN expiry or on leaving
    // a debounce state back into SCAN.
    col_d = col_drive(idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      idx_q       <= 2'd0;
      r_cap_q     <= 2'd0;
      cnt_q       <= '0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      r_cap_q     <= r_cap_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8.
// A small contact model pulls a row low while its key is down and its column
// is driven, so bounce is produced by toggling key contacts cycle by cycle.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int S = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] down = '0;   // key contact closed, bit r*4+c
  logic [3:0]  rows;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_valid = 0;

  always #5 clk = ~clk;

  keypad_if kp ();

  keypad_scanner #(
    .SETTLE_CYCLES   (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (down[r*4+c] && !kp.col[c]) rows[r] = 1'b0;
  end
  assign kp.row_sync = rows;

  always @(negedge clk) begin
    if (kp.key_valid) begin
      n_valid++;
      $display("[%0t] key event code=%h", $time, kp.key_code);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait; leaves the bench in the first cycle col shows target.
  task automatic wait_col(input logic [3:0] target, input string tag);
    int k = 0;
    while (kp.col !== target && k < 64) begin
      tick(1);
      k++;
    end
    check(tag, {28'd0, kp.col}, {28'd0, target});
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(3);
    check("rst_col",   {28'd0, kp.col},      32'hE);
    check("rst_code",  {28'd0, kp.key_code}, 32'h0);
    check("rst_valid", {31'd0, kp.key_valid}, 32'd0);
    check("rst_held",  {31'd0, kp.key_held},  32'd0);

    // ---------------- idle scan ----------------
    reset = 1'b1;                                  // cycle 0
    check("idle_c0",  {28'd0, kp.col}, 32'hE);
    tick(3);  check("idle_c3",  {28'd0, kp.col}, 32'hE);
    tick(1);  check("idle_c4",  {28'd0, kp.col}, 32'hD);
    tick(4);  check("idle_c8",  {28'd0, kp.col}, 32'hB);
    tick(4);  check("idle_c12", {28'd0, kp.col}, 32'h7);
    tick(3);  check("idle_c15", {28'd0, kp.col}, 32'h7);
    tick(1);  check("idle_c16", {28'd0, kp.col}, 32'hE);
    tick(20); check("idle_c36", {28'd0, kp.col}, 32'hD);
    check("idle_no_valid", n_valid, 0);
    $display("[%0t] idle scan done", $time);

    // ---------------- clean press r1/c2 -> 6 ----------------
    down[1*4+2] = 1'b1;
    wait_col(4'hB, "press_wait_col");
    tick(S + D - 2);
    check("press_valid_early", {31'd0, kp.key_valid}, 32'd0);
    tick(1);
    check("press_valid", {31'd0, kp.key_valid}, 32'd1);
    check("press_code",  {28'd0, kp.key_code},  32'h6);
    check("press_held",  {31'd0, kp.key_held},  32'd1);
    tick(1);
    check("press_pulse_width", {31'd0, kp.key_valid}, 32'd0);
    tick(25);
    check("press_col_frozen", {28'd0, kp.col}, 32'hB);
    check("press_one_event", n_valid, 1);
    down[1*4+2] = 1'b0;
    tick(D - 1);
    check("rel_held_before", {31'd0, kp.key_held}, 32'd1);
    check("rel_col_frozen",  {28'd0, kp.col},      32'hB);
    tick(1);
    check("rel_held_fall", {31'd0, kp.key_held}, 32'd0);
    check("rel_col_resume", {28'd0, kp.col},     32'h7);
    tick(S);
    check("rel_col_next", {28'd0, kp.col}, 32'hE);
    check("rel_no_event", n_valid, 1);
    $display("[%0t] clean press/release done", $time);

    // ---------------- press bounce ----------------
    wait_col(4'hB, "bounce_wait_col");
    tick(S - 1);
    down[1*4+2] = 1'b1;                            // cycle a (sample)
    tick(3);
    down[1*4+2] = 1'b0;                            // a+3
    tick(1);
    down[1*4+2] = 1'b1;                            // a+4
    check("bounce_abandon_col", {28'd0, kp.col},      32'h7);
    check("bounce_no_held",     {31'd0, kp.key_held}, 32'd0);
    check("bounce_no_event",    n_valid, 1);
    tick(3 * S);
    check("bounce_lap_col", {28'd0, kp.col}, 32'hB);
    tick(S + D - 2);
    check("bounce_valid_early", {31'd0, kp.key_valid}, 32'd0);
    tick(1);
    check("bounce_valid", {31'd0, kp.key_valid}, 32'd1);
    check("bounce_code",  {28'd0, kp.key_code},  32'h6);
    $display("[%0t] press bounce done", $time);

    // ---------------- release bounce ----------------
    tick(5);
    down[1*4+2] = 1'b0;                            // cycle b
    tick(3);
    down[1*4+2] = 1'b1;                            // b+3
    check("rbounce_held_mid", {31'd0, kp.key_held}, 32'd1);
    tick(2);
    down[1*4+2] = 1'b0;                            // b+5, final rise
    tick(D - 1);
    check("rbounce_held_before", {31'd0, kp.key_held}, 32'd1);
    check("rbounce_col_frozen",  {28'd0, kp.col},      32'hB);
    tick(1);
    check("rbounce_held_fall", {31'd0, kp.key_held}, 32'd0);
    check("rbounce_col",       {28'd0, kp.col},      32'h7);
    check("rbounce_events",    n_valid, 2);
    $display("[%0t] release bounce done", $time);

    // ---------------- two keys: 0 (r3/c1) and A (r0/c3) ----------------
    wait_col(4'hE, "two_wait_col");
    down[3*4+1] = 1'b1;
    down[0*4+3] = 1'b1;
    tick(S + S + D - 2);
    check("two_valid_early", {31'd0, kp.key_valid}, 32'd0);
    tick(1);
    check("two_valid0", {31'd0, kp.key_valid}, 32'd1);
    check("two_code0",  {28'd0, kp.key_code},  32'h0);
    check("two_col0",   {28'd0, kp.col},       32'hD);
    tick(20);
    check("two_single_event", n_valid, 3);
    check("two_code_hold",    {28'd0, kp.key_code}, 32'h0);
    down[3*4+1] = 1'b0;                            // cycle c
    tick(D);
    check("two_rel0_held", {31'd0, kp.key_held}, 32'd0);
    check("two_rel0_col",  {28'd0, kp.col},      32'hB);
    tick(S + S + D - 2);
    check("two_validA_early", {31'd0, kp.key_valid}, 32'd0);
    tick(1);
    check("two_validA", {31'd0, kp.key_valid}, 32'd1);
    check("two_codeA",  {28'd0, kp.key_code},  32'hA);
    check("two_colA",   {28'd0, kp.col},       32'h7);
    tick(1);
    down[0*4+3] = 1'b0;
    tick(D);
    check("two_relA_held", {31'd0, kp.key_held}, 32'd0);
    check("two_relA_col",  {28'd0, kp.col},      32'hE);
    check("two_events",    n_valid, 4);
    $display("[%0t] two-key press done", $time);

    // ---------------- reset during HELD ----------------
    down[2*4+0] = 1'b1;                            // key 7 on col0
    tick(S + D - 1);
    check("hreset_valid", {31'd0, kp.key_valid}, 32'd1);
    check("hreset_code",  {28'd0, kp.key_code},  32'h7);
    tick(3);
    reset = 1'b0;
    #1;
    check("hreset_col",   {28'd0, kp.col},       32'hE);
    check("hreset_code0", {28'd0, kp.key_code},  32'h0);
    check("hreset_held",  {31'd0, kp.key_held},  32'd0);
    check("hreset_vld",   {31'd0, kp.key_valid}, 32'd0);
    down = '0;
    tick(2);
    reset = 1'b1;
    check("hreset_rel_col", {28'd0, kp.col}, 32'hE);
    tick(40);
    check("hreset_no_event", n_valid, 5);
    check("hreset_idle_held", {31'd0, kp.key_held}, 32'd0);
    $display("[%0t] reset during held done", $time);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
